// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences ALU, memory port, IR and register file.
// Optional retire counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [3:0]            ALUctrl,
  output logic [2:0]            ImmSrc,
  output logic                  illegal,
  output logic [3:0]            state_dbg,
  output logic [CNT_WIDTH-1:0]  retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  state_t     state, next_state;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       retire;
  logic       unused_instr_bits;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};
  assign state_dbg = state;

  // funct7_5 picks SUB only for register ops; for immediates it only selects SRA
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      3'b001:  return ALU_SLL;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUctrl    = ALU_ADD;
    ImmSrc     = IMM_I;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BR:        next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = (op == OP_SW) ? IMM_S : IMM_I;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUctrl    = alu_decode(funct3, funct7_5, 1'b1);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUctrl    = alu_decode(funct3, funct7_5, 1'b0);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUctrl    = ALU_SUB;
        next_state = S_FETCH;
        case (funct3)
          3'b000: begin PCWrite = EQ;  retire = 1'b1; end
          3'b001: begin PCWrite = !EQ; retire = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset silences every output immediately so an abandoned access cannot complete
    if (!rst_n) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUctrl   = ALU_ADD;
      ImmSrc    = IMM_I;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

`ifdef MC_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_WIDTH'(1);
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired = '0;
`endif

endmodule
